// File: rtl/slave_fifo_fsm_pkg.sv
// slave_fifo_fsm_pkg: shared state encoding and parameter defaults for the slave FIFO handshake
package slave_fifo_fsm_pkg;
    typedef enum logic [1:0] {
        WAIT    = 2'd0,
        ACK     = 2'd1,
        RELEASE = 2'd2
    } state_t;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_DEPTH      = 4;
    localparam int DEF_ACK_CYCLES = 2;
    localparam int DEF_FOUR_PHASE = 0;
endpackage

// File: rtl/slave_fifo_fsm_if.sv
// slave_fifo_fsm_if: request/ack handshake plus consumer read port of the slave FIFO
interface slave_fifo_fsm_if
    import slave_fifo_fsm_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic              req;
    logic [DATA_W-1:0] data_in;
    logic              ack;
    logic [DATA_W-1:0] last_byte;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              empty;
    logic              full;
    logic [CW-1:0]     count;
    modport master (
        output req, data_in, rd_en,
        input  ack, last_byte, rd_data, empty, full, count
    );
    modport slave (
        input  req, data_in, rd_en,
        output ack, last_byte, rd_data, empty, full, count
    );
endinterface

// File: rtl/slave_fifo_buf.sv
// slave_fifo_buf: first-word fall-through receive buffer; full/empty come from the occupancy count
module slave_fifo_buf
    import slave_fifo_fsm_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [DATA_W-1:0]        i_data,
    output logic [DATA_W-1:0]        o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_push;
    logic              w_pop;
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;
    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = r_count == '0;
    assign o_full  = r_count == (AW+1)'(DEPTH);
endmodule

// File: rtl/slave_fifo_fsm.sv
// slave_fifo_fsm: req/ack slave that buffers each accepted word; ack is a registered state decode
module slave_fifo_fsm
    import slave_fifo_fsm_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ACK_CYCLES = DEF_ACK_CYCLES,
    parameter int FOUR_PHASE = DEF_FOUR_PHASE
) (
    input logic             clk,
    input logic             rst_n,
    slave_fifo_fsm_if.slave bus
);
    state_t                r_state;
    logic                  r_ack;
    logic [3:0]            r_ack_cnt;
    logic [DATA_W-1:0]     r_last_byte;
    logic                  w_accept;
    logic                  w_full;
    logic                  w_empty;
    logic [DATA_W-1:0]     w_rd_data;
    logic [$clog2(DEPTH):0] w_count;
    // full is sampled before any same-edge pop, so a pop never unblocks acceptance that edge
    assign w_accept = (r_state == WAIT) && bus.req && !w_full;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= WAIT;
            r_ack       <= 1'b0;
            r_ack_cnt   <= '0;
            r_last_byte <= '0;
        end else begin
            case (r_state)
                WAIT: if (w_accept) begin
                    r_state     <= ACK;
                    r_ack       <= 1'b1;
                    r_ack_cnt   <= '0;
                    r_last_byte <= bus.data_in;
                end
                ACK: if (r_ack_cnt == 4'(ACK_CYCLES - 1)) begin
                    r_state <= (FOUR_PHASE != 0) ? RELEASE : WAIT;
                    r_ack   <= 1'b0;
                end else begin
                    r_ack_cnt <= r_ack_cnt + 1'b1;
                end
                RELEASE: if (!bus.req) r_state <= WAIT;
                default: begin
                    r_state <= WAIT;
                    r_ack   <= 1'b0;
                end
            endcase
        end
    end
    slave_fifo_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_accept),
        .i_pop   (bus.rd_en),
        .i_data  (bus.data_in),
        .o_data  (w_rd_data),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );
    assign bus.ack       = r_ack;
    assign bus.last_byte = r_last_byte;
    assign bus.rd_data   = w_rd_data;
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.count     = w_count;
endmodule

// File: tb/tb_slave_fifo_fsm.sv
// tb_slave_fifo_fsm: two-phase (defaults) and four-phase (ACK_CYCLES=5) slaves driven by shared
// stimulus and checked every cycle against a queue-and-countdown model of the handshake
module tb_slave_fifo_fsm;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] data_in = 8'h00;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    slave_fifo_fsm_if #(.DATA_W(8), .DEPTH(4)) ifa ();
    slave_fifo_fsm_if #(.DATA_W(8), .DEPTH(4)) ifb ();
    assign ifa.req = req;
    assign ifa.data_in = data_in;
    assign ifa.rd_en = rd_en;
    assign ifb.req = req;
    assign ifb.data_in = data_in;
    assign ifb.rd_en = rd_en;

    slave_fifo_fsm u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    slave_fifo_fsm #(.ACK_CYCLES(5), .FOUR_PHASE(1)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    // model: ack cycles still owed, waiting-for-req-low flag, ordered word list
    int         m_ack [2];
    bit         m_rel [2];
    logic [7:0] m_last [2];
    logic [7:0] m_q [2][4];
    int         m_n [2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ack[i] = 0;
            m_rel[i] = 1'b0;
            m_last[i] = 8'h00;
            m_n[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit acc;
            bit pop;
            acc = m_ack[i] == 0 && !m_rel[i] && req && m_n[i] < 4;
            pop = rd_en && m_n[i] > 0;
            if (m_ack[i] > 0) begin
                m_ack[i]--;
                if (m_ack[i] == 0 && i == 1) m_rel[i] = 1'b1;
            end else if (m_rel[i]) begin
                if (!req) m_rel[i] = 1'b0;
            end else if (acc) begin
                m_ack[i] = (i == 0) ? 2 : 5;
            end
            if (pop) begin
                for (int j = 0; j < 3; j++) m_q[i][j] = m_q[i][j+1];
                m_n[i]--;
            end
            if (acc) begin
                m_q[i][m_n[i]] = data_in;
                m_n[i]++;
                m_last[i] = data_in;
            end
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input string tag, input int i, input logic ack, input logic [7:0] last,
                            input logic [7:0] rd, input logic [2:0] cnt, input logic e, input logic f);
        chk({tag, ".ack"}, int'(ack), int'(m_ack[i] > 0));
        chk({tag, ".last_byte"}, int'(last), int'(m_last[i]));
        chk({tag, ".count"}, int'(cnt), m_n[i]);
        chk({tag, ".empty"}, int'(e), int'(m_n[i] == 0));
        chk({tag, ".full"}, int'(f), int'(m_n[i] == 4));
        if (m_n[i] > 0) chk({tag, ".rd_data"}, int'(rd), int'(m_q[i][0]));
    endtask

    task automatic compare();
        cmp_inst("a", 0, ifa.ack, ifa.last_byte, ifa.rd_data, ifa.count, ifa.empty, ifa.full);
        cmp_inst("b", 1, ifb.ack, ifb.last_byte, ifb.rd_data, ifb.count, ifb.empty, ifb.full);
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        @(negedge clk);
        compare();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 1'b0;
        rd_en = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic pulse(input logic [7:0] w);
        req = 1'b1;
        data_in = w;
        cyc();
        req = 1'b0;
        idle(7);
    endtask

    initial begin
        logic [7:0] exp_pop [4];
        int acks;
        exp_pop = '{8'h22, 8'h33, 8'h44, 8'h55};
        model_reset();
        repeat (2) @(negedge clk);
        compare();
        chk("reset_empty", int'(ifa.empty), 1);
        chk("reset_count", int'(ifa.count), 0);
        rst_n = 1'b1;

        // single transfer with defaults
        req = 1'b1;
        data_in = 8'hA5;
        cyc();
        req = 1'b0;
        chk("single_ack_c2", int'(ifa.ack), 1);
        cyc();
        chk("single_ack_c3", int'(ifa.ack), 1);
        cyc();
        chk("single_ack_c4", int'(ifa.ack), 0);
        chk("single_last", int'(ifa.last_byte), 'hA5);
        chk("single_rd", int'(ifa.rd_data), 'hA5);
        chk("single_count", int'(ifa.count), 1);
        idle(6);

        // fill, backpressure, then drain in order
        do_reset();
        pulse(8'h11);
        pulse(8'h22);
        pulse(8'h33);
        pulse(8'h44);
        chk("fill_full", int'(ifa.full), 1);
        req = 1'b1;
        data_in = 8'h55;
        repeat (3) begin
            cyc();
            chk("bp_noack", int'(ifa.ack), 0);
        end
        chk("bp_head", int'(ifa.rd_data), 'h11);
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        chk("bp_pop_edge_noack", int'(ifa.ack), 0);
        cyc();
        req = 1'b0;
        chk("bp_accept_ack", int'(ifa.ack), 1);
        chk("bp_last", int'(ifa.last_byte), 'h55);
        idle(7);
        for (int j = 0; j < 4; j++) begin
            chk("drain_order", int'(ifa.rd_data), int'(exp_pop[j]));
            rd_en = 1'b1;
            cyc();
            rd_en = 1'b0;
        end
        chk("drain_empty", int'(ifa.empty), 1);

        // four-phase: held req yields one ack burst and one word
        do_reset();
        acks = 0;
        req = 1'b1;
        data_in = 8'h77;
        repeat (10) begin
            cyc();
            acks += int'(ifb.ack);
        end
        req = 1'b0;
        repeat (3) begin
            cyc();
            acks += int'(ifb.ack);
        end
        chk("fp_ack_cycles", acks, 5);
        chk("fp_count_one", int'(ifb.count), 1);
        req = 1'b1;
        data_in = 8'h78;
        cyc();
        req = 1'b0;
        chk("fp_reaccept_ack", int'(ifb.ack), 1);
        chk("fp_count_two", int'(ifb.count), 2);
        idle(7);

        // simultaneous accept and pop
        do_reset();
        pulse(8'h01);
        pulse(8'h02);
        chk("sim_count_pre", int'(ifa.count), 2);
        chk("sim_head_pre", int'(ifa.rd_data), 'h01);
        req = 1'b1;
        data_in = 8'h03;
        rd_en = 1'b1;
        cyc();
        req = 1'b0;
        rd_en = 1'b0;
        chk("sim_count_post", int'(ifa.count), 2);
        chk("sim_head_post", int'(ifa.rd_data), 'h02);
        idle(7);

        // asynchronous reset during the second ack cycle
        do_reset();
        pulse(8'h0A);
        pulse(8'h0B);
        req = 1'b1;
        data_in = 8'h0C;
        cyc();
        req = 1'b0;
        cyc();
        chk("ar_ack_pre", int'(ifa.ack), 1);
        chk("ar_count_pre", int'(ifa.count), 3);
        #2 rst_n = 1'b0;
        model_reset();
        #1 compare();
        chk("ar_ack", int'(ifa.ack), 0);
        chk("ar_count", int'(ifa.count), 0);
        chk("ar_empty", int'(ifa.empty), 1);
        chk("ar_last", int'(ifa.last_byte), 0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        chk("ar_pop_empty_count", int'(ifa.count), 0);
        chk("ar_pop_empty_ack", int'(ifa.ack), 0);

        // randomized traffic with occasional resets
        repeat (600) begin
            req = $urandom_range(0, 2) == 0;
            data_in = 8'($urandom);
            rd_en = $urandom_range(0, 3) == 0;
            rst_n = $urandom_range(0, 199) != 0;
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
